// File: rtl/uart_cmd_sequencer_if.sv
// Byte stream in from the UART receiver, command handshake out to the memory controller.
interface uart_cmd_sequencer_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Cmd_Valid;
  logic        i_Cmd_Ready;
  logic        o_Cmd_Write;
  logic [15:0] o_Cmd_Addr;
  logic [7:0]  o_Cmd_Data;
  logic        o_Frame_Err;
  logic        o_Overrun;
  logic        o_Busy;

  modport master (
    input  i_Rx_DV, i_Rx_Byte, i_Cmd_Ready,
    output o_Cmd_Valid, o_Cmd_Write, o_Cmd_Addr, o_Cmd_Data,
           o_Frame_Err, o_Overrun, o_Busy
  );

  modport slave (
    output i_Rx_DV, i_Rx_Byte, i_Cmd_Ready,
    input  o_Cmd_Valid, o_Cmd_Write, o_Cmd_Addr, o_Cmd_Data,
           o_Frame_Err, o_Overrun, o_Busy
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Parses XOR-checked UART command frames and issues one read/write command per
// frame over a valid/ready handshake; flags framing errors, timeouts and overruns.
module uart_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CLKS = 4096,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [7:0]  OP_WRITE     = 8'h57,
  parameter logic [7:0]  OP_READ      = 8'h52
) (
  input logic                  i_Clock,
  input logic                  i_Reset,
  uart_cmd_sequencer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);
  // Expiry is taken on the edge where the counter would reach TIMEOUT_CLKS-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 2);

  typedef enum logic [2:0] {
    IDLE, OPCODE, ADDR_HI, ADDR_LO, DATA, CHECK, ISSUE
  } state_t;

  state_t           state_q, state_d;
  logic             write_q, write_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       chk_q, chk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, busy_q;

  logic       rx_dv;
  logic [7:0] rx_byte;

  assign rx_dv   = bus.i_Rx_DV;
  assign rx_byte = bus.i_Rx_Byte;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      valid_q <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_dv && (rx_byte == SYNC_BYTE)) begin
          state_d = OPCODE;
          chk_d   = '0;
          data_d  = '0;
        end
      end

      // Bytes landing while a command is pending, including the transfer cycle, are lost.
      ISSUE: begin
        cnt_d = '0;
        if (rx_dv) begin
          ovr_d = 1'b1;
        end
        if (bus.i_Cmd_Ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        if (rx_dv) begin
          cnt_d = '0;
          case (state_q)
            OPCODE: begin
              if ((rx_byte == OP_WRITE) || (rx_byte == OP_READ)) begin
                write_d = (rx_byte == OP_WRITE);
                chk_d   = rx_byte;
                state_d = ADDR_HI;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
            ADDR_HI: begin
              addr_d[15:8] = rx_byte;
              chk_d        = chk_q ^ rx_byte;
              state_d      = ADDR_LO;
            end
            ADDR_LO: begin
              addr_d[7:0] = rx_byte;
              chk_d       = chk_q ^ rx_byte;
              state_d     = write_q ? DATA : CHECK;
            end
            DATA: begin
              data_d  = rx_byte;
              chk_d   = chk_q ^ rx_byte;
              state_d = CHECK;
            end
            CHECK: begin
              if (rx_byte == chk_q) begin
                state_d = ISSUE;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end
            default: state_d = IDLE;
          endcase
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  assign bus.o_Cmd_Valid = valid_q;
  assign bus.o_Cmd_Write = write_q;
  assign bus.o_Cmd_Addr  = addr_q;
  assign bus.o_Cmd_Data  = data_q;
  assign bus.o_Frame_Err = err_q;
  assign bus.o_Overrun   = ovr_q;
  assign bus.o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed frames with hand-computed expectations; a forked monitor scores commands and error pulses.
`timescale 1ns/1ps
module tb_uart_cmd_sequencer;

  localparam int unsigned TO = 16;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          hold;
    int          rise;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_cyc = 0;
  cmd_t cmd_q[$];
  int   err_q[$];

  uart_cmd_sequencer_if bus_if();

  uart_cmd_sequencer #(.TIMEOUT_CLKS(TO)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.i_Rx_DV   = 1'b1;
    bus_if.i_Rx_Byte = b;
    @(posedge clk);
    #1;
    last_cyc = cyc;
    bus_if.i_Rx_DV   = 1'b0;
    bus_if.i_Rx_Byte = 8'h00;
  endtask

  task automatic send_write(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] d, input logic [7:0] chk);
    send_byte(8'hA5); send_byte(8'h57); send_byte(hi); send_byte(lo);
    send_byte(d); send_byte(chk);
  endtask

  task automatic send_read(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] chk);
    send_byte(8'hA5); send_byte(8'h52); send_byte(hi); send_byte(lo); send_byte(chk);
  endtask

  task automatic push_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                          input int hold);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.data = data; c.hold = hold; c.rise = last_cyc;
    cmd_q.push_back(c);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},   32'(bus_if.o_Cmd_Valid), 32'd0);
    check({tag, "_busy"},    32'(bus_if.o_Busy),      32'd0);
    check({tag, "_err"},     32'(bus_if.o_Frame_Err), 32'd0);
    check({tag, "_overrun"}, 32'(bus_if.o_Overrun),   32'd0);
    check({tag, "_write"},   32'(bus_if.o_Cmd_Write), 32'd0);
    check({tag, "_addr"},    32'(bus_if.o_Cmd_Addr),  32'd0);
    check({tag, "_data"},    32'(bus_if.o_Cmd_Data),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_idle(tag);
    cmd_q.delete();
    err_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus_if.i_Rx_DV     = 1'b0;
    bus_if.i_Rx_Byte   = 8'h00;
    bus_if.i_Cmd_Ready = 1'b0;

    fork
      begin : monitor
        logic valid_prev = 1'b0;
        logic expect_drop = 1'b0;
        int   hold = 0;
        cmd_t e;
        forever begin
          @(negedge clk);
          if (rst) begin
            valid_prev = 1'b0; expect_drop = 1'b0; hold = 0;
          end else begin
            if (expect_drop) begin
              check("valid_drop", 32'(bus_if.o_Cmd_Valid), 32'd0);
              expect_drop = 1'b0;
            end
            if (bus_if.o_Cmd_Valid) begin
              if (cmd_q.size() == 0) begin
                fail_event("unexpected_cmd");
              end else begin
                e = cmd_q[0];
                if (!valid_prev) check("cmd_latency", 32'(cyc), 32'(e.rise));
                hold++;
                check("cmd_write", 32'(bus_if.o_Cmd_Write), 32'(e.wr));
                check("cmd_addr",  32'(bus_if.o_Cmd_Addr),  32'(e.addr));
                check("cmd_data",  32'(bus_if.o_Cmd_Data),  32'(e.data));
                if (bus_if.i_Cmd_Ready) begin
                  if (e.hold != 0) check("cmd_hold", 32'(hold), 32'(e.hold));
                  void'(cmd_q.pop_front());
                  hold = 0;
                  expect_drop = 1'b1;
                end
              end
            end
            if (bus_if.o_Frame_Err) begin
              if (bus_if.o_Cmd_Valid && !valid_prev) fail_event("err_with_valid_rise");
              if (err_q.size() == 0) fail_event("unexpected_frame_err");
              else check("frame_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
            valid_prev = bus_if.o_Cmd_Valid;
          end
        end
      end
    join_none

    #2;
    check_idle("por");
    idle(2);
    rst = 1'b0;
    idle(2);

    // write frame, ready already high
    bus_if.i_Cmd_Ready = 1'b1;
    send_write(8'h12, 8'h34, 8'h5A, 8'h2B);
    push_cmd(1'b1, 16'h1234, 8'h5A, 1);
    idle(3);
    check("busy_after_write", 32'(bus_if.o_Busy), 32'd0);

    // read frame with backpressure: valid held 6 cycles
    bus_if.i_Cmd_Ready = 1'b0;
    send_read(8'h00, 8'h10, 8'h42);
    push_cmd(1'b0, 16'h0010, 8'h00, 6);
    idle(5);
    bus_if.i_Cmd_Ready = 1'b1;
    idle(2);
    check("busy_after_read", 32'(bus_if.o_Busy), 32'd0);

    // bad checksum, bad opcode, then a good read
    send_write(8'h12, 8'h34, 8'h5A, 8'h2C);
    err_q.push_back(last_cyc);
    idle(2);
    send_byte(8'hA5);
    send_byte(8'h41);
    err_q.push_back(last_cyc);
    idle(2);
    send_read(8'h00, 8'h10, 8'h42);
    push_cmd(1'b0, 16'h0010, 8'h00, 1);
    idle(3);

    // timeout: error lands 15 clocks after the opcode strobe
    send_byte(8'hA5);
    send_byte(8'h52);
    err_q.push_back(last_cyc + int'(TO) - 1);
    idle(20);
    check("busy_after_timeout", 32'(bus_if.o_Busy), 32'd0);

    // byte on the expiry cycle wins; frame completes
    send_byte(8'hA5);
    send_byte(8'h52);
    idle(14);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h42);
    push_cmd(1'b0, 16'h0010, 8'h00, 1);
    idle(3);

    // overrun while command pending; fields preserved
    bus_if.i_Cmd_Ready = 1'b0;
    send_write(8'hAB, 8'hCD, 8'hEF, 8'hDE);
    push_cmd(1'b1, 16'hABCD, 8'hEF, 0);
    send_byte(8'h55);
    idle(1);
    check("overrun_set", 32'(bus_if.o_Overrun), 32'd1);
    idle(3);
    check("overrun_pending_valid", 32'(bus_if.o_Cmd_Valid), 32'd1);
    bus_if.i_Cmd_Ready = 1'b1;
    idle(2);
    check("overrun_sticky", 32'(bus_if.o_Overrun), 32'd1);

    // byte on the transfer cycle is dropped; next frame parses from IDLE
    send_read(8'h00, 8'h10, 8'h42);
    push_cmd(1'b0, 16'h0010, 8'h00, 1);
    send_byte(8'hA5);
    send_read(8'h00, 8'h10, 8'h42);
    push_cmd(1'b0, 16'h0010, 8'h00, 1);
    idle(3);
    check("overrun_still_sticky", 32'(bus_if.o_Overrun), 32'd1);

    // reset in ADDR_LO
    send_byte(8'hA5);
    send_byte(8'h57);
    send_byte(8'h12);
    do_reset("rst_addr_lo");
    idle(2);

    // reset during ISSUE
    bus_if.i_Cmd_Ready = 1'b0;
    send_write(8'h12, 8'h34, 8'h5A, 8'h2B);
    push_cmd(1'b1, 16'h1234, 8'h5A, 0);
    idle(2);
    do_reset("rst_issue");
    idle(2);

    // garbage in IDLE, then a normal frame
    bus_if.i_Cmd_Ready = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_write(8'h12, 8'h34, 8'h5A, 8'h2B);
    push_cmd(1'b1, 16'h1234, 8'h5A, 1);
    idle(5);
    check("overrun_cleared", 32'(bus_if.o_Overrun), 32'd0);
    check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    check("err_q_empty", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
